// File: rtl/spi_pkg.sv
// Shared SPI types: the byte type used by the master, slaves and receive buffers.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// A push while full is accepted only if a pop frees the head slot in the same
// cycle; a pop while empty is ignored. Overflow reporting is left to the user.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = SPI_BYTE_W
) (
  input  logic                     i_clk,
  input  logic                     i_rstN,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_rdata  = o_empty ? '0 : r_mem[r_rptr];

  // Storage is not reset; an empty FIFO presents zero on the read port instead.
  always_ff @(posedge i_clk) begin
    if (i_rstN && w_doPush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks net traffic.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_doPop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive buffer behind an SPI slave: turns each rising edge of the slave's
// ready level into one FIFO write of the received byte, and reports occupancy,
// high-water and a sticky overflow flag to the local consumer.
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned HIWAT = 6
) (
  input  logic                   Clk_i,
  input  logic                   Rst_ni,
  input  logic                   Ready_i,
  input  spi_byte_t              Rcvd_i,
  output spi_byte_t              Data_o,
  output logic                   Valid_o,
  input  logic                   Pop_i,
  output logic [$clog2(DEPTH):0] Count_o,
  output logic                   Full_o,
  output logic                   Hiwat_o,
  output logic                   Overflow_o,
  input  logic                   ClrOvf_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic r_rdyQ;
  logic r_overflow;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_dropped;

  assign w_push     = Ready_i & ~r_rdyQ;
  assign Valid_o    = ~w_empty;
  assign Full_o     = w_full;
  assign Hiwat_o    = (Count_o >= CW'(HIWAT));
  assign Overflow_o = r_overflow;
  assign w_dropped  = w_push & w_full & ~(Pop_i & Valid_o);

  // Edge register follows Ready_i even in reset (it is 0 whenever Ready_i was
  // low), so a Ready_i held high across reset release reads as a level, not a new byte.
  always_ff @(posedge Clk_i) begin
    r_rdyQ <= Ready_i;
  end

  // Sticky overflow: a dropped byte sets it and wins over a same-cycle clear.
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      r_overflow <= 1'b0;
    end else if (w_dropped) begin
      r_overflow <= 1'b1;
    end else if (ClrOvf_i) begin
      r_overflow <= 1'b0;
    end
  end

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPI_BYTE_W)
  ) u_fifo (
    .i_clk   (Clk_i),
    .i_rstN  (Rst_ni),
    .i_push  (w_push),
    .i_pop   (Pop_i),
    .i_wdata (Rcvd_i),
    .o_rdata (Data_o),
    .o_count (Count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Bench for spi_rx_buffer: stimulus queues the bytes it expects to come out,
// a negedge monitor compares every popped byte, and status is checked directly.
module tb_spi_rx_buffer;

  logic       Clk_i;
  logic       Rst_ni;
  logic       Ready_i;
  logic [7:0] Rcvd_i;
  logic [7:0] Data_o;
  logic       Valid_o;
  logic       Pop_i;
  logic [3:0] Count_o;
  logic       Full_o;
  logic       Hiwat_o;
  logic       Overflow_o;
  logic       ClrOvf_i;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];
  logic [7:0] monExp;

  spi_rx_buffer #(.DEPTH(8), .HIWAT(6)) dut (
    .Clk_i      (Clk_i),
    .Rst_ni     (Rst_ni),
    .Ready_i    (Ready_i),
    .Rcvd_i     (Rcvd_i),
    .Data_o     (Data_o),
    .Valid_o    (Valid_o),
    .Pop_i      (Pop_i),
    .Count_o    (Count_o),
    .Full_o     (Full_o),
    .Hiwat_o    (Hiwat_o),
    .Overflow_o (Overflow_o),
    .ClrOvf_i   (ClrOvf_i)
  );

  // Free-running 100 MHz clock.
  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: whenever the consumer takes a byte, it must match the oldest expected byte.
  always @(negedge Clk_i) begin
    if (Rst_ni && Pop_i && Valid_o) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL popData: actual %02h, required no byte", Data_o);
      end else begin
        monExp = expQ.pop_front();
        if (Data_o !== monExp) begin
          errors++;
          $display("[TB] FAIL popData: actual %02h, required %02h", Data_o, monExp);
        end
      end
    end
  end

  // Drive one cycle of inputs, then settle just after the active edge.
  task automatic applyStimulus(input logic rdy, input logic [7:0] data,
                               input logic pop, input logic clr);
    Ready_i  = rdy;
    Rcvd_i   = data;
    Pop_i    = pop;
    ClrOvf_i = clr;
    @(posedge Clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
    end
  endtask

  // One Ready_i pulse (one cycle high, one low); record the byte if it should be kept.
  task automatic pulseByte(input logic [7:0] b, input bit accept);
    if (accept) expQ.push_back(b);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic popOnce();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Directed sequence.
  initial begin
    Rst_ni = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    Rst_ni = 1'b1;
    checkOutput("rstCount", int'(Count_o), 0);
    checkOutput("rstValid", int'(Valid_o), 0);
    checkOutput("rstFull", int'(Full_o), 0);
    checkOutput("rstHiwat", int'(Hiwat_o), 0);
    checkOutput("rstOvf", int'(Overflow_o), 0);
    checkOutput("rstData", int'(Data_o), 0);

    // Single byte: visible the cycle after the edge, then popped away.
    expQ.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("a5Valid", int'(Valid_o), 1);
    checkOutput("a5Data", int'(Data_o), 'hA5);
    checkOutput("a5Count", int'(Count_o), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    popOnce();
    checkOutput("a5PopCount", int'(Count_o), 0);
    checkOutput("a5PopValid", int'(Valid_o), 0);

    // Pop while empty has no effect.
    popOnce();
    checkOutput("emptyPopCount", int'(Count_o), 0);

    // Ready held high for 20 cycles is a single byte.
    expQ.push_back(8'h3C);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("holdCount", int'(Count_o), 1);
    popOnce();
    checkOutput("holdPopCount", int'(Count_o), 0);

    // Fill to full, watching high-water and full decode.
    for (int i = 1; i <= 8; i++) begin
      pulseByte(8'(i), 1'b1);
      checkOutput($sformatf("fillCount%0d", i), int'(Count_o), i);
      checkOutput($sformatf("fillHiwat%0d", i), int'(Hiwat_o), (i >= 6) ? 1 : 0);
      checkOutput($sformatf("fillFull%0d", i), int'(Full_o), (i == 8) ? 1 : 0);
    end
    pulseByte(8'hFF, 1'b0);
    checkOutput("ovfSet", int'(Overflow_o), 1);
    checkOutput("ovfCount", int'(Count_o), 8);
    for (int i = 0; i < 8; i++) popOnce();
    checkOutput("drainCount", int'(Count_o), 0);
    checkOutput("drainOvfSticky", int'(Overflow_o), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovfClear", int'(Overflow_o), 0);

    // Full with a coincident push and pop: accepted, no overflow, new byte last.
    for (int i = 0; i < 8; i++) pulseByte(8'h10 + 8'(i), 1'b1);
    expQ.push_back(8'hEE);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("coinOvf", int'(Overflow_o), 0);
    checkOutput("coinCount", int'(Count_o), 8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    // Overflowing push with a same-cycle clear: set wins.
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b1);
    checkOutput("setWinsOvf", int'(Overflow_o), 1);
    checkOutput("setWinsCount", int'(Count_o), 8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) popOnce();
    checkOutput("coinDrainCount", int'(Count_o), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation with Ready_i high across release.
    for (int i = 0; i < 8; i++) pulseByte(8'h20 + 8'(i), 1'b1);
    pulseByte(8'h2F, 1'b0);
    for (int i = 0; i < 3; i++) popOnce();
    checkOutput("preRstCount", int'(Count_o), 5);
    checkOutput("preRstOvf", int'(Overflow_o), 1);
    Rst_ni = 1'b0;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    Rst_ni = 1'b1;
    expQ.delete();
    checkOutput("midRstCount", int'(Count_o), 0);
    checkOutput("midRstValid", int'(Valid_o), 0);
    checkOutput("midRstOvf", int'(Overflow_o), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("heldReadyNoPush", int'(Count_o), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Wrap traffic: 24 bytes, each edge coincident with a pop of the previous byte.
    for (int i = 0; i < 24; i++) begin
      expQ.push_back(8'h40 + 8'(i));
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("wrapCount", int'(Count_o), 1);
    popOnce();
    checkOutput("wrapDrainCount", int'(Count_o), 0);
    checkOutput("wrapOvf", int'(Overflow_o), 0);
    checkOutput("queueDrained", expQ.size(), 0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
